// File: rtl/conv_beat_sequencer_pkg.sv
// Shared definitions for the conv input-stream beat sequencer: limits, tuser layout,
// FSM states and the layer descriptor payload.
package conv_beat_sequencer_pkg;

    localparam int unsigned KERNEL_W_MAX       = 3;
    localparam int unsigned KERNEL_H_MAX       = 3;
    localparam int unsigned BEATS_CONFIG_3X3_1 = 20;
    localparam int unsigned BEATS_CONFIG_1X1_1 = 12;
    localparam int unsigned IM_CIN_MAX         = 1024;
    localparam int unsigned IM_COLS_MAX        = 384;
    localparam int unsigned IM_BLOCKS_MAX      = 32;

    localparam int unsigned BITS_CIN      = $clog2(IM_CIN_MAX);
    localparam int unsigned BITS_COLS     = $clog2(IM_COLS_MAX);
    localparam int unsigned BITS_BLOCKS   = $clog2(IM_BLOCKS_MAX);
    localparam int unsigned BITS_KERNEL_W = $clog2(KERNEL_W_MAX);
    localparam int unsigned BITS_CFG_CNT  = $clog2(BEATS_CONFIG_3X3_1 + 1);
    localparam int unsigned STATS_W       = 32;

    // conv tuser bit positions
    localparam int unsigned I_IS_NOT_MAX      = 0;
    localparam int unsigned I_IS_MAX          = 1;
    localparam int unsigned I_IS_1X1          = 2;
    localparam int unsigned I_IS_LRELU        = 3;
    localparam int unsigned I_IS_TOP_BLOCK    = 4;
    localparam int unsigned I_IS_BOTTOM_BLOCK = 5;
    localparam int unsigned I_IS_COLS_1_K2    = 6;
    localparam int unsigned I_IS_CONFIG       = 7;
    localparam int unsigned I_IS_ACC_LAST     = 8;
    localparam int unsigned I_KERNEL_W_1      = 9;
    localparam int unsigned TUSER_WIDTH_CONV_IN = I_KERNEL_W_1 + BITS_KERNEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_DATA   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [BITS_CIN-1:0]      cin_1;
        logic [BITS_COLS-1:0]     cols_1;
        logic [BITS_BLOCKS-1:0]   blocks_1;
        logic [BITS_KERNEL_W-1:0] kernel_w_1;
        logic                     is_1x1;
        logic                     is_max;
        logic                     is_not_max;
        logic                     is_lrelu;
    } layer_desc_t;

    function automatic logic [TUSER_WIDTH_CONV_IN-1:0] pack_tuser(
        input layer_desc_t d,
        input logic        top,
        input logic        bottom,
        input logic        cols_k2,
        input logic        is_cfg,
        input logic        acc_last
    );
        logic [TUSER_WIDTH_CONV_IN-1:0] t;
        t                                   = '0;
        t[I_IS_NOT_MAX]                     = d.is_not_max;
        t[I_IS_MAX]                         = d.is_max;
        t[I_IS_1X1]                         = d.is_1x1;
        t[I_IS_LRELU]                       = d.is_lrelu;
        t[I_IS_TOP_BLOCK]                   = top;
        t[I_IS_BOTTOM_BLOCK]                = bottom;
        t[I_IS_COLS_1_K2]                   = cols_k2;
        t[I_IS_CONFIG]                      = is_cfg;
        t[I_IS_ACC_LAST]                    = acc_last;
        t[I_KERNEL_W_1 +: BITS_KERNEL_W]    = d.kernel_w_1;
        return t;
    endfunction

    // Column where the kernel's right edge hits the image edge, clamped at zero
    function automatic logic [BITS_COLS-1:0] cols_k2_idx(input layer_desc_t d);
        logic [BITS_COLS-1:0] half;
        half = BITS_COLS'(d.kernel_w_1 >> 1);
        return (d.cols_1 >= half) ? (d.cols_1 - half) : '0;
    endfunction

endpackage

// File: rtl/conv_beat_sequencer_if.sv
// Descriptor and beat-stream bundle for conv_beat_sequencer.
// Optional CONV_SEQ_STATS_EN adds beat/stall statistics outputs.
interface conv_beat_sequencer_if;
    import conv_beat_sequencer_pkg::*;

    logic                           s_cfg_valid;
    logic                           s_cfg_ready;
    logic [BITS_CIN-1:0]            s_cfg_cin_1;
    logic [BITS_COLS-1:0]           s_cfg_cols_1;
    logic [BITS_BLOCKS-1:0]         s_cfg_blocks_1;
    logic [BITS_KERNEL_W-1:0]       s_cfg_kernel_w_1;
    logic                           s_cfg_is_1x1;
    logic                           s_cfg_is_max;
    logic                           s_cfg_is_not_max;
    logic                           s_cfg_is_lrelu;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic [TUSER_WIDTH_CONV_IN-1:0] m_axis_tuser;
    logic                           m_axis_tlast;
    logic                           busy;
`ifdef CONV_SEQ_STATS_EN
    logic [STATS_W-1:0]             beat_count;
    logic [STATS_W-1:0]             stall_count;

    modport master (
        output s_cfg_valid, s_cfg_cin_1, s_cfg_cols_1, s_cfg_blocks_1, s_cfg_kernel_w_1,
               s_cfg_is_1x1, s_cfg_is_max, s_cfg_is_not_max, s_cfg_is_lrelu, m_axis_tready,
        input  s_cfg_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy,
               beat_count, stall_count
    );
    modport slave (
        input  s_cfg_valid, s_cfg_cin_1, s_cfg_cols_1, s_cfg_blocks_1, s_cfg_kernel_w_1,
               s_cfg_is_1x1, s_cfg_is_max, s_cfg_is_not_max, s_cfg_is_lrelu, m_axis_tready,
        output s_cfg_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy,
               beat_count, stall_count
    );
`else
    modport master (
        output s_cfg_valid, s_cfg_cin_1, s_cfg_cols_1, s_cfg_blocks_1, s_cfg_kernel_w_1,
               s_cfg_is_1x1, s_cfg_is_max, s_cfg_is_not_max, s_cfg_is_lrelu, m_axis_tready,
        input  s_cfg_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy
    );
    modport slave (
        input  s_cfg_valid, s_cfg_cin_1, s_cfg_cols_1, s_cfg_blocks_1, s_cfg_kernel_w_1,
               s_cfg_is_1x1, s_cfg_is_max, s_cfg_is_not_max, s_cfg_is_lrelu, m_axis_tready,
        output s_cfg_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy
    );
`endif
endinterface

// File: rtl/conv_seq_loop_cnt.sv
// Up-counter that wraps to zero after reaching a run-time limit; last_c flags the limit.
module conv_seq_loop_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_c
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign last_c = (cnt_q == limit_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_c ? '0 : (cnt_q + WIDTH'(1));
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/conv_beat_sequencer.sv
// Layer scheduler: takes one descriptor, emits config beats then cin/col/block data beats.
// Optional CONV_SEQ_STATS_EN adds saturating beat and stall counters.
module conv_beat_sequencer
    import conv_beat_sequencer_pkg::*;
(
    input logic                  aclk,
    input logic                  areset,
    conv_beat_sequencer_if.slave bus
);
    seq_state_e                     state_q, state_d;
    logic [BITS_CFG_CNT-1:0]        cfg_cnt_q, cfg_cnt_d;
    layer_desc_t                    desc_q, desc_d, desc_in;
    logic                           tvalid_q, tvalid_d;
    logic [TUSER_WIDTH_CONV_IN-1:0] tuser_q, tuser_d;
    logic                           tlast_q, tlast_d;
    logic                           busy_q, busy_d;
    logic                           cfg_ready_q, cfg_ready_d;

    logic                           accept_c, hs_c, load_data_c;
    logic [BITS_CIN-1:0]            cin_cnt;
    logic [BITS_COLS-1:0]           col_cnt;
    logic [BITS_BLOCKS-1:0]         blk_cnt;
    logic                           cin_last_c, col_last_c, blk_last_c;
    logic [TUSER_WIDTH_CONV_IN-1:0] data_tuser_c;
    logic                           data_last_c;

    assign desc_in = '{
        cin_1:      bus.s_cfg_cin_1,
        cols_1:     bus.s_cfg_cols_1,
        blocks_1:   bus.s_cfg_blocks_1,
        kernel_w_1: bus.s_cfg_kernel_w_1,
        is_1x1:     bus.s_cfg_is_1x1,
        is_max:     bus.s_cfg_is_max,
        is_not_max: bus.s_cfg_is_not_max,
        is_lrelu:   bus.s_cfg_is_lrelu
    };

    assign accept_c = bus.s_cfg_valid && cfg_ready_q;
    assign hs_c     = tvalid_q && bus.m_axis_tready;
    // Loop counters point at the next data beat to be loaded into the output register
    assign load_data_c = hs_c && (((state_q == ST_CONFIG) && (cfg_cnt_q == '0)) ||
                                  ((state_q == ST_DATA) && !tlast_q));

    conv_seq_loop_cnt #(.WIDTH(BITS_CIN)) u_cin_cnt (
        .aclk(aclk), .areset(areset), .clr(accept_c), .en(load_data_c),
        .limit_i(desc_q.cin_1), .cnt_o(cin_cnt), .last_c(cin_last_c)
    );

    conv_seq_loop_cnt #(.WIDTH(BITS_COLS)) u_col_cnt (
        .aclk(aclk), .areset(areset), .clr(accept_c), .en(load_data_c && cin_last_c),
        .limit_i(desc_q.cols_1), .cnt_o(col_cnt), .last_c(col_last_c)
    );

    conv_seq_loop_cnt #(.WIDTH(BITS_BLOCKS)) u_blk_cnt (
        .aclk(aclk), .areset(areset), .clr(accept_c),
        .en(load_data_c && cin_last_c && col_last_c),
        .limit_i(desc_q.blocks_1), .cnt_o(blk_cnt), .last_c(blk_last_c)
    );

    assign data_tuser_c = pack_tuser(desc_q, (blk_cnt == '0), blk_last_c,
                                     (col_cnt == cols_k2_idx(desc_q)), 1'b0, cin_last_c);
    assign data_last_c  = cin_last_c && col_last_c && blk_last_c;

    always_comb begin
        state_d     = state_q;
        cfg_cnt_d   = cfg_cnt_q;
        desc_d      = desc_q;
        tvalid_d    = tvalid_q;
        tuser_d     = tuser_q;
        tlast_d     = tlast_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d   = ST_CONFIG;
                    desc_d    = desc_in;
                    cfg_cnt_d = desc_in.is_1x1 ? BITS_CFG_CNT'(BEATS_CONFIG_1X1_1)
                                               : BITS_CFG_CNT'(BEATS_CONFIG_3X3_1);
                    tvalid_d  = 1'b1;
                    tuser_d   = pack_tuser(desc_in, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    tlast_d   = 1'b0;
                end
            end
            ST_CONFIG: begin
                if (hs_c) begin
                    if (cfg_cnt_q == '0) begin
                        state_d = ST_DATA;
                        tuser_d = data_tuser_c;
                        tlast_d = data_last_c;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q - BITS_CFG_CNT'(1);
                    end
                end
            end
            ST_DATA: begin
                if (hs_c) begin
                    if (tlast_q) begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tuser_d  = '0;
                        tlast_d  = 1'b0;
                    end else begin
                        tuser_d = data_tuser_c;
                        tlast_d = data_last_c;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tuser_d  = '0;
                tlast_d  = 1'b0;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            cfg_cnt_q   <= '0;
            desc_q      <= '0;
            tvalid_q    <= 1'b0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            desc_q      <= desc_d;
            tvalid_q    <= tvalid_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign bus.s_cfg_ready   = cfg_ready_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.busy          = busy_q;

`ifdef CONV_SEQ_STATS_EN
    logic [STATS_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;

    // Per-layer statistics, restarted by each accepted descriptor
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept_c) begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (hs_c && (beat_cnt_q != '1)) begin
                beat_cnt_d = beat_cnt_q + STATS_W'(1);
            end
            if (tvalid_q && !bus.m_axis_tready && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + STATS_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.beat_count  = beat_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_beat_sequencer.sv
// Bench for conv_beat_sequencer: descriptor table + scoreboard of expected beats,
// plus back-to-back, mid-layer reset and (with CONV_SEQ_STATS_EN) statistics sequences.
module tb_conv_beat_sequencer;
    import conv_beat_sequencer_pkg::*;

    localparam int unsigned TW = TUSER_WIDTH_CONV_IN;

    typedef struct {
        int cin_1;
        int cols_1;
        int blocks_1;
        int kw_1;
        bit is_1x1;
        bit is_max;
        bit is_not_max;
        bit is_lrelu;
        int ready_pct;
        int stalls;
        int exp_beats;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tuser;
        logic          tlast;
    } beat_t;

    logic aclk = 1'b0;
    logic areset;

    conv_beat_sequencer_if bus();

    conv_beat_sequencer dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int            n_vec = 0;
    int            n_err = 0;
    beat_t         exp_q[$];
    int            cyc = 0;
    int            ready_pct = 100;
    int            stall_left = 0;
    bit            mon_en = 1'b1;
    int            beats_seen = 0;
    int            tlast_hs_cyc = -10;
    bit            stall_prev = 1'b0;
    logic [TW-1:0] stall_tuser;
    logic          stall_tlast;
    vec_t          table_v[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [TW-1:0] make_tuser(input vec_t v, input bit top, input bit bot,
                                                 input bit k2, input bit cfg, input bit acc);
        logic [TW-1:0] t;
        t = '0;
        t[I_IS_NOT_MAX]      = v.is_not_max;
        t[I_IS_MAX]          = v.is_max;
        t[I_IS_1X1]          = v.is_1x1;
        t[I_IS_LRELU]        = v.is_lrelu;
        t[I_IS_TOP_BLOCK]    = top;
        t[I_IS_BOTTOM_BLOCK] = bot;
        t[I_IS_COLS_1_K2]    = k2;
        t[I_IS_CONFIG]       = cfg;
        t[I_IS_ACC_LAST]     = acc;
        t[I_KERNEL_W_1 +: BITS_KERNEL_W] = BITS_KERNEL_W'(v.kw_1);
        return t;
    endfunction

    // Reference beat stream for one layer
    task automatic push_layer(input vec_t v);
        beat_t b;
        int    n_cfg;
        int    k2col;
        n_cfg = v.is_1x1 ? 13 : 21;
        k2col = (v.cols_1 >= v.kw_1 / 2) ? (v.cols_1 - v.kw_1 / 2) : 0;
        for (int i = 0; i < n_cfg; i++) begin
            b.tuser = make_tuser(v, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            b.tlast = 1'b0;
            exp_q.push_back(b);
        end
        for (int blk = 0; blk <= v.blocks_1; blk++)
            for (int col = 0; col <= v.cols_1; col++)
                for (int ch = 0; ch <= v.cin_1; ch++) begin
                    b.tuser = make_tuser(v, blk == 0, blk == v.blocks_1, col == k2col,
                                         1'b0, ch == v.cin_1);
                    b.tlast = (blk == v.blocks_1) && (col == v.cols_1) && (ch == v.cin_1);
                    exp_q.push_back(b);
                end
    endtask

    // One clock: drive tready after the edge, then sample and score at the falling edge
    task automatic step();
        beat_t e;
        @(posedge aclk);
        #1;
        cyc++;
        if (stall_left > 0 && bus.m_axis_tvalid === 1'b1 && (cyc % 5) == 0) begin
            bus.m_axis_tready = 1'b0;
            stall_left--;
        end else if (ready_pct >= 100) begin
            bus.m_axis_tready = 1'b1;
        end else begin
            bus.m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        end
        @(negedge aclk);
        if (stall_prev && !areset)
            check("stall_hold",
                  64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser}),
                  64'({1'b1, stall_tlast, stall_tuser}));
        stall_prev  = bus.m_axis_tvalid && !bus.m_axis_tready && !areset;
        stall_tuser = bus.m_axis_tuser;
        stall_tlast = bus.m_axis_tlast;
        if (mon_en && bus.m_axis_tvalid && bus.m_axis_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_extra: got tuser 0x%0h tlast %0b, expected no beat",
                         bus.m_axis_tuser, bus.m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("beat%0d", beats_seen),
                      64'({bus.m_axis_tlast, bus.m_axis_tuser}), 64'({e.tlast, e.tuser}));
            end
            if (bus.m_axis_tlast) tlast_hs_cyc = cyc;
        end
    endtask

    task automatic drive_fields(input vec_t v);
        bus.s_cfg_cin_1      = BITS_CIN'(v.cin_1);
        bus.s_cfg_cols_1     = BITS_COLS'(v.cols_1);
        bus.s_cfg_blocks_1   = BITS_BLOCKS'(v.blocks_1);
        bus.s_cfg_kernel_w_1 = BITS_KERNEL_W'(v.kw_1);
        bus.s_cfg_is_1x1     = v.is_1x1;
        bus.s_cfg_is_max     = v.is_max;
        bus.s_cfg_is_not_max = v.is_not_max;
        bus.s_cfg_is_lrelu   = v.is_lrelu;
    endtask

    task automatic send_desc(input vec_t v);
        int n;
        n = 0;
        beats_seen = 0;
        drive_fields(v);
        bus.s_cfg_valid = 1'b1;
        while (!bus.s_cfg_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("cfg_ready_timeout", 64'(bus.s_cfg_ready), 64'(1));
        step();
        bus.s_cfg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_axis_tvalid) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int   accepts;
        int   h;
        int   n;
        vec_t v;

        areset = 1'b1;
        bus.s_cfg_valid = 1'b0;
        bus.m_axis_tready = 1'b0;
        drive_fields('{0, 0, 0, 0, 0, 0, 0, 0, 100, 0, 0});
        step();
        step();
        check("rst_tvalid",    64'(bus.m_axis_tvalid), 64'(0));
        check("rst_tlast",     64'(bus.m_axis_tlast),  64'(0));
        check("rst_tuser",     64'(bus.m_axis_tuser),  64'(0));
        check("rst_busy",      64'(bus.busy),          64'(0));
        check("rst_cfg_ready", 64'(bus.s_cfg_ready),   64'(1));
        areset = 1'b0;
        step();

        //            cin cols blk kw 1x1 max nmax lrelu rdy stalls beats
        table_v[0] = '{1,  3,   1,  2, 0,  0,  1,   0,    100, 4,    37};
        table_v[1] = '{0,  0,   0,  0, 1,  0,  1,   0,    100, 0,    14};
        table_v[2] = '{1,  3,   1,  2, 0,  0,  1,   0,    50,  0,    37};
        table_v[3] = '{2,  1,   0,  2, 0,  1,  0,   1,    70,  0,    27};
        table_v[4] = '{0,  0,   2,  2, 0,  0,  1,   0,    100, 3,    24};
        table_v[5] = '{3,  2,   1,  0, 1,  0,  1,   1,    60,  0,    37};

        for (int i = 0; i < 6; i++) begin
            ready_pct  = table_v[i].ready_pct;
            stall_left = table_v[i].stalls;
            push_layer(table_v[i]);
            send_desc(table_v[i]);
            check($sformatf("v%0d_busy_during", i), 64'(bus.busy), 64'(1));
            drain($sformatf("v%0d", i));
            check($sformatf("v%0d_beats", i), 64'(beats_seen), 64'(table_v[i].exp_beats));
            check($sformatf("v%0d_busy_after", i), 64'(bus.busy), 64'(0));
            check($sformatf("v%0d_ready_after", i), 64'(bus.s_cfg_ready), 64'(1));
`ifdef CONV_SEQ_STATS_EN
            if (i == 0) begin
                check("stats_beat_count",  64'(bus.beat_count),  64'(37));
                check("stats_stall_count", 64'(bus.stall_count), 64'(4));
            end
`endif
        end

        // Back-to-back layers with s_cfg_valid held high
        v = table_v[1];
        ready_pct  = 100;
        stall_left = 0;
        push_layer(v);
        push_layer(v);
        drive_fields(v);
        beats_seen = 0;
        tlast_hs_cyc = -10;
        bus.s_cfg_valid = 1'b1;
        accepts = 0;
        n = 0;
        while (n < 200) begin
            if (bus.s_cfg_ready) begin
                accepts++;
                if (accepts == 2) begin
                    check("b2b_accept_cycle", 64'(cyc), 64'(tlast_hs_cyc + 1));
                    check("b2b_bubble", 64'(bus.m_axis_tvalid), 64'(0));
                    step();
                    bus.s_cfg_valid = 1'b0;
                    check("b2b_first_beat", 64'(bus.m_axis_tvalid), 64'(1));
                    break;
                end
            end
            step();
            n++;
        end
        bus.s_cfg_valid = 1'b0;
        if (n >= 200) check("b2b_second_accept", 64'(accepts), 64'(2));
        drain("b2b");
        check("b2b_beats", 64'(beats_seen), 64'(28));

        // Reset while the fifth data beat is presented
        mon_en = 1'b0;
        ready_pct = 100;
        send_desc(table_v[0]);
        h = 0;
        n = 0;
        while (n < 200) begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (h == 25) break;
                h++;
            end
            step();
            n++;
        end
        check("rst_mid_reached", 64'(h), 64'(25));
        check("rst_mid_is_data", 64'(bus.m_axis_tuser[I_IS_CONFIG]), 64'(0));
        areset = 1'b1;
        step();
        check("rst_mid_tvalid",    64'(bus.m_axis_tvalid), 64'(0));
        check("rst_mid_busy",      64'(bus.busy),          64'(0));
        check("rst_mid_cfg_ready", 64'(bus.s_cfg_ready),   64'(1));
        check("rst_mid_tuser",     64'(bus.m_axis_tuser),  64'(0));
        check("rst_mid_tlast",     64'(bus.m_axis_tlast),  64'(0));
        areset = 1'b0;
        mon_en = 1'b1;
        exp_q.delete();
        push_layer(table_v[3]);
        send_desc(table_v[3]);
        drain("post_rst");
        check("post_rst_beats", 64'(beats_seen), 64'(27));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
